// File: rtl/instr_fetch_queue.sv
// Instruction fetch queue: issues sequential word fetches, buffers in-order responses
// in a DEPTH-entry FIFO for decode, and discards stale responses after a redirect.
// Optional build macro IFQ_SYSCALL_HALT_EN: stop fetching after a syscall word is queued.
module instr_fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter int          ADDR_W   = 10,
    parameter logic [31:0] RESET_PC = 32'd0
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_gnt,
    input  logic              imem_rvalid,
    input  logic [31:0]       imem_rdata,
    output logic              if_valid,
    output logic [31:0]       if_instr,
    output logic [31:0]       if_pc_next,
    input  logic              id_ready,
    input  logic              redirect_valid,
    input  logic [31:0]       redirect_pc,
    output logic              halted
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // Handshakes: a transfer happens on a rising edge where valid (imem_req / if_valid)
    // and ready (imem_gnt / id_ready) are both high; valid never waits on ready.
    logic [31:0]      fetch_pc;
    logic [CNT_W-1:0] out_cnt;
    logic [CNT_W-1:0] drop_cnt;
    logic [CNT_W-1:0] occ;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             halt_q;
    logic [31:0]      instr_q [DEPTH];
    logic [31:0]      pcn_q   [DEPTH];

    logic [CNT_W:0]   inflight;
    logic             grant;
    logic             retire;
    logic             push;
    logic             pop;
    logic             halt_set;
    logic [31:0]      resp_pc;
    logic [CNT_W-1:0] out_cnt_nxt;

    assign inflight = {1'b0, out_cnt} + {1'b0, occ};
    // rst_n gate keeps the request low while the counters sit in reset.
    assign imem_req = rst_n && !halt_q && !redirect_valid
                      && (inflight < (CNT_W+1)'(DEPTH));
    assign imem_addr = fetch_pc[ADDR_W-1:0];

    assign grant  = imem_req && imem_gnt;
    assign retire = imem_rvalid && (out_cnt != '0);
    assign push   = retire && (drop_cnt == '0) && !redirect_valid;
    assign pop    = if_valid && id_ready && !redirect_valid;

    // With nothing owed to the discard counter, every outstanding request is part of
    // the current sequential run ending at fetch_pc-1, so the oldest is fetch_pc-out_cnt.
    assign resp_pc = fetch_pc - 32'(out_cnt);

    assign out_cnt_nxt = out_cnt + CNT_W'(grant) - CNT_W'(retire);

`ifdef IFQ_SYSCALL_HALT_EN
    logic is_syscall;
    assign is_syscall = (imem_rdata[31:26] == 6'b000000) && (imem_rdata[5:0] == 6'b001100);
    assign halt_set   = push && is_syscall && !halt_q;
`else
    assign halt_set = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc <= RESET_PC;
            out_cnt  <= '0;
            drop_cnt <= '0;
            occ      <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            halt_q   <= 1'b0;
        end else begin
            out_cnt <= out_cnt_nxt;
            if (redirect_valid) begin
                fetch_pc <= redirect_pc;
                drop_cnt <= out_cnt_nxt;
                occ      <= '0;
                rd_ptr   <= '0;
                wr_ptr   <= '0;
                halt_q   <= 1'b0;
            end else begin
                if (grant)
                    fetch_pc <= fetch_pc + 32'd1;
                // A halt abandons every word still owed, including one granted this edge.
                if (halt_set)
                    drop_cnt <= out_cnt_nxt;
                else if (retire && (drop_cnt != '0))
                    drop_cnt <= drop_cnt - CNT_W'(1);
                if (push)
                    wr_ptr <= wr_ptr + PTR_W'(1);
                if (pop)
                    rd_ptr <= rd_ptr + PTR_W'(1);
                occ <= occ + CNT_W'(push) - CNT_W'(pop);
                if (halt_set)
                    halt_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            instr_q[wr_ptr] <= imem_rdata;
            pcn_q[wr_ptr]   <= resp_pc + 32'd1;
        end
    end

    assign if_valid   = (occ != '0);
    assign if_instr   = instr_q[rd_ptr];
    assign if_pc_next = pcn_q[rd_ptr];
    assign halted     = halt_q;

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Bench for instr_fetch_queue: directed scenarios plus randomized traffic, checked against
// a queue-level model of the memory and of the word stream decode should see.
module tb_instr_fetch_queue;

    localparam int          DEPTH    = 4;
    localparam int          ADDR_W   = 10;
    localparam logic [31:0] RESET_PC = 32'd0;
`ifdef IFQ_SYSCALL_HALT_EN
    localparam bit HALT_EN = 1'b1;
`else
    localparam bit HALT_EN = 1'b0;
`endif

    logic              clk;
    logic              rst_n;
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_gnt;
    logic              imem_rvalid;
    logic [31:0]       imem_rdata;
    logic              if_valid;
    logic [31:0]       if_instr;
    logic [31:0]       if_pc_next;
    logic              id_ready;
    logic              redirect_valid;
    logic [31:0]       redirect_pc;
    logic              halted;

    instr_fetch_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .RESET_PC(RESET_PC)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .if_valid(if_valid), .if_instr(if_instr), .if_pc_next(if_pc_next),
        .id_ready(id_ready), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .halted(halted)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // model state
    typedef struct {
        logic [31:0] pc;
        int          due;
        int          epoch;
    } req_t;

    req_t        mem_q[$];
    logic [63:0] exp_q[$];
    logic [31:0] exp_fetch;
    int          epoch;
    bit          m_halted;
    int          cyc;
    bit          prev_redir;

    // knobs and stats
    int          p_gnt, p_ready, p_redir, lat_min, lat_max;
    bit          force_redir, redir_busy, redir_seen;
    logic [31:0] redir_target;
    bit          sys_en;
    logic [31:0] sys_addr;
    int          n_grants, n_pops, n_dropped;
    logic [31:0] last_pcn;
    logic [31:0] last_gaddr;

    int total;
    int bad;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] pc);
        logic [31:0] a;
        a = 32'(pc[ADDR_W-1:0]);
        if (sys_en && a == sys_addr)
            return 32'h0000_000C;
        return {a[15:0] ^ 16'hC3A5, a[15:0] ^ 16'h5A3C};
    endfunction

    function automatic bit is_sys(input logic [31:0] w);
        return (w[31:26] == 6'd0) && (w[5:0] == 6'b001100);
    endfunction

    function automatic logic [31:0] rand_target();
        case ($urandom_range(3))
            0:       return $urandom();
            1:       return 32'hFFFF_FFFE;
            default: return 32'($urandom_range(2047));
        endcase
    endfunction

    // driver: one clock cycle of stimulus, checks and model update
    task automatic step();
        bit          redir, g, rv;
        bit          exp_req;
        req_t        h;
        logic [63:0] w;
        @(negedge clk);
        cyc++;
        imem_gnt = ($urandom_range(99) < p_gnt);
        id_ready = ($urandom_range(99) < p_ready);
        rv = (mem_q.size() > 0) && (mem_q[0].due <= cyc);
        imem_rvalid = rv;
        imem_rdata  = rv ? mem_word(mem_q[0].pc) : $urandom();
        if (force_redir)     redir = 1'b1;
        else if (redir_busy) redir = (exp_q.size() > 0) && rv;
        else                 redir = ($urandom_range(99) < p_redir);
        redirect_valid = redir;
        redirect_pc    = (force_redir || redir_busy) ? redir_target : rand_target();
        #1;
        if (prev_redir)
            check("if_valid_after_redirect", 32'(if_valid), 32'd0);
        exp_req = !m_halted && !redir && (mem_q.size() + exp_q.size() < DEPTH);
        check("imem_req", 32'(imem_req), 32'(exp_req));
        check("if_valid", 32'(if_valid), 32'(exp_q.size() != 0));
        if (exp_q.size() != 0) begin
            check("if_instr", if_instr, exp_q[0][63:32]);
            check("if_pc_next", if_pc_next, exp_q[0][31:0]);
        end
        check("halted", 32'(halted), 32'(m_halted));

        g = imem_req && imem_gnt;
        if (g) begin
            check("imem_addr", 32'(imem_addr), 32'(exp_fetch[ADDR_W-1:0]));
            last_gaddr = 32'(imem_addr);
            mem_q.push_back('{pc: exp_fetch, due: cyc + int'($urandom_range(lat_max, lat_min)), epoch: epoch});
            exp_fetch = exp_fetch + 32'd1;
            n_grants++;
        end
        if (exp_q.size() > 0 && id_ready && !redir) begin
            w = exp_q.pop_front();
            last_pcn = w[31:0];
            n_pops++;
        end
        if (rv) begin
            h = mem_q.pop_front();
            if (!redir && h.epoch == epoch) begin
                w = {mem_word(h.pc), h.pc + 32'd1};
                exp_q.push_back(w);
                if (HALT_EN && !m_halted && is_sys(w[63:32])) begin
                    m_halted = 1'b1;
                    epoch++;
                end
            end else begin
                n_dropped++;
            end
        end
        if (redir) begin
            exp_q.delete();
            epoch++;
            exp_fetch = redirect_pc;
            m_halted  = 1'b0;
            redir_seen = 1'b1;
        end
        prev_redir = redir;
    endtask

    // asynchronous reset, asserted mid-cycle and released between edges
    task automatic do_reset();
        @(negedge clk);
        #3;
        rst_n          = 1'b0;
        imem_rvalid    = 1'b0;
        imem_gnt       = 1'b0;
        redirect_valid = 1'b0;
        id_ready       = 1'b0;
        #1;
        check("rst_imem_req", 32'(imem_req), 32'd0);
        check("rst_if_valid", 32'(if_valid), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_imem_addr", 32'(imem_addr), 32'(RESET_PC[ADDR_W-1:0]));
        mem_q.delete();
        exp_q.delete();
        epoch++;
        exp_fetch  = RESET_PC;
        m_halted   = 1'b0;
        prev_redir = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    task automatic set_knobs(input int g, input int r, input int rd, input int lmin, input int lmax);
        p_gnt = g; p_ready = r; p_redir = rd; lat_min = lmin; lat_max = lmax;
    endtask

    initial begin
        total = 0; bad = 0; cyc = 0; epoch = 0;
        rst_n = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
        id_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        force_redir = 1'b0; redir_busy = 1'b0; redir_target = '0; redir_seen = 1'b0;
        sys_en = 1'b0; sys_addr = 32'd5; last_pcn = '0; last_gaddr = '0;
        exp_fetch = RESET_PC; m_halted = 1'b0; prev_redir = 1'b0;
        n_grants = 0; n_pops = 0; n_dropped = 0;

        // streaming: 1-cycle memory, always granted, decode always ready
        set_knobs(100, 100, 0, 1, 1);
        do_reset();
        n_pops = 0;
        repeat (20) step();
        check("stream_pops", 32'(n_pops >= 16), 32'd1);

        // decode stalled: exactly DEPTH grants, head is address RESET_PC
        set_knobs(100, 0, 0, 1, 1);
        do_reset();
        n_grants = 0;
        repeat (10) step();
        check("stall_grants", 32'(n_grants), 32'(DEPTH));
        check("stall_head_pcn", if_pc_next, RESET_PC + 32'd1);

        // redirect with 3 outstanding on a 3-cycle memory
        set_knobs(100, 0, 0, 3, 3);
        do_reset();
        repeat (3) step();
        n_dropped = 0;
        force_redir = 1'b1; redir_target = 32'h40;
        step();
        force_redir = 1'b0;
        for (int i = 0; i < 20 && !if_valid; i++) step();
        check("redir_if_valid", 32'(if_valid), 32'd1);
        check("redir_pc_next", if_pc_next, 32'h41);
        check("redir_dropped", 32'(n_dropped), 32'd3);

        // redirect on the same edge as a pop and a response
        set_knobs(100, 100, 0, 1, 1);
        do_reset();
        repeat (5) step();
        redir_busy = 1'b1; redir_target = 32'h100; redir_seen = 1'b0;
        for (int i = 0; i < 10 && !redir_seen; i++) step();
        redir_busy = 1'b0;
        check("busy_redirect_seen", 32'(redir_seen), 32'd1);
        step();
        repeat (6) step();

        // reset pulse mid-stream with 2 outstanding
        set_knobs(100, 100, 0, 3, 3);
        do_reset();
        repeat (2) step();
        check("pre_reset_outstanding", 32'(mem_q.size()), 32'd2);
        do_reset();
        n_grants = 0;
        step();
        check("refetch_grants", 32'(n_grants), 32'd1);
        check("refetch_addr", last_gaddr, 32'(RESET_PC[ADDR_W-1:0]));
        repeat (10) step();

`ifdef IFQ_SYSCALL_HALT_EN
        // syscall at address 5 halts fetch
        set_knobs(100, 100, 0, 1, 1);
        sys_en = 1'b1; sys_addr = 32'd5;
        do_reset();
        repeat (15) step();
        check("sys_halted", 32'(halted), 32'd1);
        check("sys_imem_req", 32'(imem_req), 32'd0);
        check("sys_last_pcn", last_pcn, 32'd6);
        force_redir = 1'b1; redir_target = 32'd0;
        step();
        force_redir = 1'b0;
        step();
        check("sys_unhalt", 32'(halted), 32'd0);
        sys_en = 1'b0;
        repeat (10) step();
`endif

        // randomized traffic
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if (i % 200 == 0) begin
                lat_min = $urandom_range(2, 1);
                set_knobs($urandom_range(100, 30), $urandom_range(100, 20),
                          $urandom_range(6, 0), lat_min, $urandom_range(4, lat_min));
            end
            if (i % 1000 == 999)
                do_reset();
            step();
        end
        check("random_progress", 32'(n_pops > 500), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/instr_fetch_queue.md
INSTR_FETCH_QUEUE -- requirements
Module: instr_fetch_queue

Interface
REQ-001 SHALL provide parameter DEPTH, default 4, queue entries (power of two, 2..16).
REQ-002 SHALL provide parameter ADDR_W, default 10, instruction-memory word-address width.
REQ-003 SHALL provide parameter RESET_PC, default 0, first fetch word address.
REQ-004 SHALL provide port clk input 1, the single clock, all state on rising edge.
REQ-005 SHALL provide port rst_n input 1, asynchronous active-low reset.
REQ-006 SHALL provide port imem_req output 1, fetch request valid.
REQ-007 SHALL provide port imem_addr output ADDR_W, word address of request, equal to fetch_pc[ADDR_W-1:0].
REQ-008 SHALL provide port imem_gnt input 1, request accepted when imem_req and imem_gnt are high on an edge.
REQ-009 SHALL provide port imem_rvalid input 1, in-order response strobe, at least 1 cycle after grant.
REQ-010 SHALL provide port imem_rdata input 32, response instruction word.
REQ-011 SHALL provide port if_valid output 1, queue head valid to decode.
REQ-012 SHALL provide port if_instr output 32, head instruction.
REQ-013 SHALL provide port if_pc_next output 32, head word address + 1.
REQ-014 SHALL provide port id_ready input 1, decode accepts head when if_valid and id_ready are high on an edge.
REQ-015 SHALL provide ports redirect_valid input 1 and redirect_pc input 32, the jump/branch/JR target from the execute stages.
REQ-016 SHALL provide port halted output 1, fetch stopped by syscall (tied 0 without the macro).

Function
REQ-017 SHALL hold fetch_pc, a DEPTH-entry FIFO of {instr, pc_next}, outstanding count out_cnt, and discard count drop_cnt.
REQ-018 SHALL assert imem_req only when out_cnt + occupancy < DEPTH, not halted and redirect_valid low; each grant increments fetch_pc by 1 (mod 2^32) and out_cnt by 1.
REQ-019 SHALL, on imem_rvalid with drop_cnt = 0, push {imem_rdata, pc+1} in order, where pc is the word address of that request, and decrement out_cnt.
REQ-020 SHALL, on imem_rvalid with drop_cnt > 0, discard the word and decrement drop_cnt and out_cnt.
REQ-021 SHALL present the FIFO head combinationally on if_instr/if_pc_next; if_valid = occupancy > 0.
REQ-022 SHALL support push and pop on the same edge with occupancy unchanged; push to full is impossible by REQ-018.
REQ-023 SHALL zero-latency pass nothing: minimum grant-to-if_valid latency is response latency + 1 cycle.
REQ-024 SHALL, on redirect_valid high at an edge, empty the FIFO, set fetch_pc = redirect_pc, set drop_cnt = out_cnt minus responses retired that edge, and ignore any same-edge pop, push or grant.
REQ-025 SHALL drive if_valid low in the cycle after a redirect; imem_req MAY assert with imem_addr = redirect_pc[ADDR_W-1:0] in that cycle.
REQ-026 SHALL let a later redirect override an earlier one; drop_cnt always equals words still owed by memory.
REQ-027 SHALL keep if_instr/if_pc_next stable while if_valid is high and id_ready is low.

Reset
REQ-028 SHALL, while rst_n is low, immediately force fetch_pc = RESET_PC, FIFO empty, out_cnt = 0, drop_cnt = 0, imem_req = 0, if_valid = 0, halted = 0.
REQ-029 SHALL discard any response arriving during reset; memory is required to be reset together with this block.
REQ-030 SHALL issue its first request on the first edge after rst_n deasserts.

Configuration
REQ-031 SHALL, with IFQ_SYSCALL_HALT_EN defined, set halted on push of a word with opcode 000000 and func 001100, stop new requests, drop responses for requests already issued, and clear halted only on redirect or reset.
REQ-032 SHALL, without IFQ_SYSCALL_HALT_EN, treat syscall as an ordinary word and tie halted to 0.

Verification
REQ-033 SHALL cover: reset, gnt=1, 1-cycle memory, id_ready=1 -> if_pc_next 1,2,3... every cycle, addresses 0,1,2...
REQ-034 SHALL cover: id_ready=0 for 10 cycles -> exactly DEPTH=4 grants, if_valid held, head instr at address 0 stable.
REQ-035 SHALL cover: 3-cycle memory latency, redirect_pc=0x40 with 3 outstanding -> 3 responses dropped, next if_pc_next = 0x41.
REQ-036 SHALL cover: redirect coinciding with pop and rvalid -> no pop counted, word dropped, queue empty next cycle.
REQ-037 SHALL cover: with IFQ_SYSCALL_HALT_EN, syscall at address 5 -> halted=1, imem_req=0, last if_pc_next = 6.
REQ-038 SHALL cover: rst_n pulsed low mid-stream with 2 outstanding -> all outputs reset asynchronously, refetch from RESET_PC.
